if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage directly downstream of pc_reg. Takes the current PC, runs one
//  Wishbone-classic read per instruction on the instruction port, and loads the IF/ID
//  pipeline register (instruction, PC, valid, fault) for decode.
//  Drives if_stall_o back to pc_reg so the PC advances only when an instruction is accepted.
// PARAMETERS
//  NOP_INSN     32'h00000013  instruction inserted on bubbles/flush (addi x0,x0,0)
//  BUS_TIMEOUT  255           cycles in S_WAIT without ack/err before a fault (1..255)
// PORTS
//  clk_i          in   1   clock, all state on rising edge
//  rst_i          in   1   reset, asynchronous, active-low
//  pc_i           in   32  current PC from pc_reg
//  if_stall_o     out  1   1 = pc_reg holds; 0 = pc_reg loads next PC this edge
//  id_stall_i     in   1   decode stalled, IF/ID must hold
//  flush_i        in   1   kill in-flight/buffered fetch (taken branch/trap)
//  iport_addr_o   out  32  fetch address (word aligned, bits[1:0] forced 0)
//  iport_cyc_o    out  1   bus cycle active
//  iport_stb_o    out  1   strobe (equals iport_cyc_o)
//  iport_data_i   in   32  read data, valid with ack
//  iport_ack_i    in   1   transfer done
//  iport_err_i    in   1   bus error
//  id_instr_o     out  32  IF/ID instruction
//  id_pc_o        out  32  IF/ID PC of id_instr_o
//  id_valid_o     out  1   IF/ID holds a real instruction
//  id_fault_o     out  1   fetch faulted (bus err, timeout, misaligned pc_i)
// BEHAVIOUR
//  Reset (rst_i=0, async): state=S_REQ; cyc/stb=0; addr=0; id_instr_o=NOP_INSN;
//   id_pc_o=0; id_valid_o=0; id_fault_o=0; kill=0; timeout counter=0. if_stall_o=1.
//  S_REQ: edge latches addr<=pc_i, cyc/stb<=1, cnt<=0 -> S_WAIT. If pc_i[1:0]!=0: no bus
//   cycle; treat as fault accept (see accept) this cycle, stay S_REQ.
//  S_WAIT: cyc/stb held, addr stable; cnt increments each cycle.
//   ack_i|err_i|cnt==BUS_TIMEOUT ends cycle: cyc/stb<=0 same edge. fault = err_i|timeout.
//   ack and err both high: err wins. kill set or flush_i: discard, if_stall_o=0, -> S_REQ.
//   else id_stall_i=0: accept -> S_REQ. else buffer {data,addr,fault} -> S_HOLD.
//  S_HOLD: id_stall_i=0: accept from buffer -> S_REQ. flush_i: discard, if_stall_o=0 -> S_REQ.
//  accept: if_stall_o=0 (combinational, that cycle); edge loads id_instr_o (NOP_INSN if
//   fault), id_pc_o=fetch addr, id_valid_o=1, id_fault_o=fault.
//  flush_i in S_WAIT without ack: kill<=1; bus cycle is never abandoned; kill clears on end.
//  if_stall_o=1 in every cycle except accept/discard. Integration: pc_source holds the
//   redirect target while if_stall_o=1, so a discard loads it into pc_reg.
//  IF/ID when no accept: flush_i=1 -> NOP_INSN, valid=0, fault=0 (flush beats id_stall_i);
//   else id_stall_i=1 -> hold; else -> NOP_INSN, valid=0, fault=0 (bubble).
//  Latency: zero-wait ack gives 1 instr / 2 cycles (S_REQ, S_WAIT). Ack N cycles after
//   cyc rises -> IF/ID valid at edge N+1.
//  Reset mid-cycle: cyc/stb drop immediately; in-flight data ignored.
// TESTING
//  1 Reset then zero-wait ack, pc 0,4,8: id_pc_o 0,4,8, valid=1 every 2nd cycle, no stall hold.
//  2 Ack after 3 waits, data 32'hDEADBEEF @pc 0x100: cyc high 4 cycles, addr stable,
//    id_instr_o=DEADBEEF, id_pc_o=0x100, if_stall_o low exactly 1 cycle.
//  3 id_stall_i=1 when ack arrives: S_HOLD, IF/ID unchanged, cyc=0. Release 2 cycles later
//    -> buffered instr loaded, pc advances once.
//  4 flush_i mid-WAIT, ack 2 cycles later: data discarded, id_valid_o=0, next addr = redirect pc.
//  5 err_i (with ack) @0x200 -> id_fault_o=1, instr=NOP_INSN, pc=0x200. Never ack ->
//    fault after 255 cycles. pc_i=0x202 -> fault, no cyc.
//  6 Assert rst_i=0 during S_WAIT: cyc/stb/valid low asynchronously, restart from S_REQ.

Source files
------------

// File: rtl/if_fetch.sv
// IF stage: one Wishbone-classic read per PC, feeding the IF/ID register.
// Holds a finished fetch while decode stalls; drains a killed cycle on flush.
module if_fetch #(
  parameter logic [31:0] NOP_INSN    = 32'h0000_0013,
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic        if_stall_o,
  input  logic        id_stall_i,
  input  logic        flush_i,
  output logic [31:0] iport_addr_o,
  output logic        iport_cyc_o,
  output logic        iport_stb_o,
  input  logic [31:0] iport_data_i,
  input  logic        iport_ack_i,
  input  logic        iport_err_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic        id_valid_o,
  output logic        id_fault_o
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  localparam logic [7:0] TMO = 8'(BUS_TIMEOUT);

  state_t      state;
  logic [7:0]  cnt;
  logic        kill;
  logic [31:0] buf_instr;
  logic        buf_fault;

  logic        misalign;
  logic        bus_end;
  logic        bus_fault;
  logic        accept;
  logic        discard;
  logic [31:0] acc_instr;
  logic [31:0] acc_pc;
  logic        acc_fault;

  assign misalign  = pc_i[1:0] != 2'b00;
  assign bus_end   = iport_ack_i | iport_err_i | (cnt == TMO);
  // only meaningful when bus_end: err, or timeout with no ack
  assign bus_fault = iport_err_i | ~iport_ack_i;

  always_comb begin
    accept    = 1'b0;
    discard   = 1'b0;
    acc_instr = NOP_INSN;
    acc_pc    = iport_addr_o;
    acc_fault = 1'b0;
    unique case (state)
      S_REQ: begin
        if (misalign && !id_stall_i && !flush_i) begin
          accept    = 1'b1;
          acc_pc    = pc_i;
          acc_fault = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus_end) begin
          if (kill || flush_i) begin
            discard = 1'b1;
          end else if (!id_stall_i) begin
            accept    = 1'b1;
            acc_fault = bus_fault;
            acc_instr = bus_fault ? NOP_INSN : iport_data_i;
          end
        end
      end
      S_HOLD: begin
        if (flush_i) begin
          discard = 1'b1;
        end else if (!id_stall_i) begin
          accept    = 1'b1;
          acc_fault = buf_fault;
          acc_instr = buf_instr;
        end
      end
      default: ;
    endcase
  end

  assign if_stall_o  = ~rst_i | ~(accept | discard);
  assign iport_stb_o = iport_cyc_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= S_REQ;
      cnt          <= 8'd0;
      kill         <= 1'b0;
      buf_instr    <= NOP_INSN;
      buf_fault    <= 1'b0;
      iport_addr_o <= 32'd0;
      iport_cyc_o  <= 1'b0;
    end else begin
      unique case (state)
        S_REQ: begin
          if (!misalign) begin
            iport_addr_o <= {pc_i[31:2], 2'b00};
            iport_cyc_o  <= 1'b1;
            cnt          <= 8'd0;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus_end) begin
            iport_cyc_o <= 1'b0;
            kill        <= 1'b0;
            cnt         <= 8'd0;
            if (accept || discard) begin
              state <= S_REQ;
            end else begin
              buf_instr <= bus_fault ? NOP_INSN : iport_data_i;
              buf_fault <= bus_fault;
              state     <= S_HOLD;
            end
          end else begin
            cnt <= cnt + 8'd1;
            if (flush_i) kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (accept || discard) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

  // IF/ID register; id_pc_o keeps its last value across bubbles
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      id_instr_o <= NOP_INSN;
      id_pc_o    <= 32'd0;
      id_valid_o <= 1'b0;
      id_fault_o <= 1'b0;
    end else if (accept) begin
      id_instr_o <= acc_instr;
      id_pc_o    <= acc_pc;
      id_valid_o <= 1'b1;
      id_fault_o <= acc_fault;
    end else if (flush_i || !id_stall_i) begin
      id_instr_o <= NOP_INSN;
      id_valid_o <= 1'b0;
      id_fault_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: bus slave, pc_reg and decode modelled at transaction level.
// Directed scenarios first, then randomized waits/errors/stalls/flushes.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        if_stall_o;
  logic        id_stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] iport_addr_o;
  logic        iport_cyc_o;
  logic        iport_stb_o;
  logic [31:0] iport_data_i = '0;
  logic        iport_ack_i = 1'b0;
  logic        iport_err_i = 1'b0;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        id_valid_o;
  logic        id_fault_o;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk_i(clk), .rst_i(rst_i), .pc_i(pc_i),
    .if_stall_o(if_stall_o), .id_stall_i(id_stall_i),
    .flush_i(flush_i), .iport_addr_o(iport_addr_o),
    .iport_cyc_o(iport_cyc_o), .iport_stb_o(iport_stb_o),
    .iport_data_i(iport_data_i), .iport_ack_i(iport_ack_i),
    .iport_err_i(iport_err_i), .id_instr_o(id_instr_o),
    .id_pc_o(id_pc_o), .id_valid_o(id_valid_o),
    .id_fault_o(id_fault_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        fault;
  } id_t;

  id_t         exp_id, held;
  logic [31:0] pc, cur_addr, redir, data_cfg;
  bit          busy, hv, killed, redir_v;
  bit          never_ack, err_cfg, rnd;
  bit          stall_nxt, flush_nxt;
  bit          c_cyc, c_nstall, c_load;
  int          widx, wait_cfg;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic do_reset(input logic [31:0] p);
    rst_i = 1'b0;
    pc = p; pc_i = p;
    busy = 0; hv = 0; killed = 0; redir_v = 0; widx = 0;
    stall_nxt = 0; flush_nxt = 0;
    id_stall_i = 0; flush_i = 0;
    iport_ack_i = 0; iport_err_i = 0;
    exp_id = '{32'h0, NOP, 1'b0, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    check("rst_cyc", iport_cyc_o, 0);
    check("rst_stb", iport_stb_o, 0);
    check("rst_addr", iport_addr_o, 0);
    check("rst_valid", id_valid_o, 0);
    check("rst_instr", id_instr_o, NOP);
    check("rst_idpc", id_pc_o, 0);
    check("rst_fault", id_fault_o, 0);
    check("rst_stall", if_stall_o, 1);
    rst_i = 1'b1;
  endtask

  // One clock: drive slave/pc/decode, predict, then check IF/ID.
  task automatic cycle();
    id_t ent;
    bit  load, free, ends;
    load = 0; free = 0; ent = '0;
    iport_ack_i = 0; iport_err_i = 0;
    iport_data_i = $urandom;
    if (iport_cyc_o && !never_ack && widx == wait_cfg) begin
      iport_ack_i  = 1;
      iport_err_i  = err_cfg;
      iport_data_i = data_cfg;
    end
    pc_i = pc;
    id_stall_i = stall_nxt;
    flush_i = flush_nxt;
    @(negedge clk);
    check("cyc", iport_cyc_o, busy);
    check("stb", iport_stb_o, busy);
    if (busy) begin
      check("addr", iport_addr_o, cur_addr);
      ends = iport_ack_i || iport_err_i || widx == TO;
      if (ends) begin
        ent.pc = cur_addr;
        ent.valid = 1;
        ent.fault = iport_err_i | ~iport_ack_i;
        ent.instr = ent.fault ? NOP : iport_data_i;
        if (killed || flush_i) free = 1;
        else if (!id_stall_i) load = 1;
        else begin held = ent; hv = 1; end
        busy = 0; killed = 0; widx = 0;
      end else begin
        killed = killed | flush_i;
        widx++;
      end
    end else if (hv) begin
      if (flush_i) begin free = 1; hv = 0; end
      else if (!id_stall_i) begin load = 1; ent = held; hv = 0; end
    end else if (pc[1:0] != 2'b00) begin
      if (!id_stall_i && !flush_i) begin
        load = 1;
        ent = '{pc, NOP, 1'b1, 1'b1};
      end
    end else begin
      busy = 1; cur_addr = pc; widx = 0;
      if (rnd) begin
        wait_cfg = $urandom_range(0, 4);
        err_cfg  = ($urandom_range(0, 7) == 0);
        data_cfg = $urandom;
      end
    end
    check("if_stall", if_stall_o, !(load || free));
    c_cyc = iport_cyc_o;
    c_nstall = !if_stall_o;
    c_load = load;
    if (load || free) begin
      pc = redir_v ? redir : pc + 32'd4;
      redir_v = 0;
    end
    if (load) exp_id = ent;
    else if (flush_i || !id_stall_i) begin
      exp_id.instr = NOP;
      exp_id.valid = 0;
      exp_id.fault = 0;
    end
    @(posedge clk);
    #1;
    check("id_valid", id_valid_o, exp_id.valid);
    check("id_instr", id_instr_o, exp_id.instr);
    check("id_fault", id_fault_o, exp_id.fault);
    if (exp_id.valid) check("id_pc", id_pc_o, exp_id.pc);
  endtask

  initial begin
    int ncyc, nlow;
    rnd = 0; never_ack = 0; err_cfg = 0;
    wait_cfg = 0; data_cfg = 32'h1234_5678;

    // zero-wait: one instruction every two cycles
    do_reset(32'h0);
    repeat (6) cycle();
    check("t1_pc", id_pc_o, 32'h8);
    check("t1_valid", id_valid_o, 1);

    // three wait states
    do_reset(32'h100);
    wait_cfg = 3; data_cfg = 32'hDEAD_BEEF;
    ncyc = 0; nlow = 0; c_load = 0;
    for (int i = 0; i < 20 && !c_load; i++) begin
      cycle();
      ncyc += int'(c_cyc);
      nlow += int'(c_nstall);
    end
    check("t2_done", c_load, 1);
    check("t2_cyc_len", ncyc, 4);
    check("t2_stall_low", nlow, 1);
    check("t2_instr", id_instr_o, 32'hDEAD_BEEF);
    check("t2_pc", id_pc_o, 32'h100);

    // decode stall at ack: buffer, then release
    do_reset(32'h700);
    wait_cfg = 1; data_cfg = 32'hCAFE_0001; stall_nxt = 1;
    repeat (5) cycle();
    check("t3_cyc", iport_cyc_o, 0);
    check("t3_held", id_valid_o, 0);
    stall_nxt = 0;
    cycle();
    check("t3_pc", id_pc_o, 32'h700);
    check("t3_instr", id_instr_o, 32'hCAFE_0001);
    check("t3_nstall", c_nstall, 1);
    cycle();
    check("t3_next", iport_addr_o, 32'h704);

    // flush mid-wait, ack two cycles later
    do_reset(32'h600);
    wait_cfg = 3;
    cycle(); cycle();
    flush_nxt = 1; redir = 32'h400; redir_v = 1;
    cycle();
    flush_nxt = 0;
    cycle(); cycle();
    check("t4_valid", id_valid_o, 0);
    cycle(); cycle();
    check("t4_redir", iport_addr_o, 32'h400);

    // bus error with ack
    do_reset(32'h200);
    wait_cfg = 1; err_cfg = 1; c_load = 0;
    for (int i = 0; i < 20 && !c_load; i++) cycle();
    check("t5_err_fault", id_fault_o, 1);
    check("t5_err_instr", id_instr_o, NOP);
    check("t5_err_pc", id_pc_o, 32'h200);
    err_cfg = 0;

    // timeout
    do_reset(32'h500);
    never_ack = 1; ncyc = 0; c_load = 0;
    for (int i = 0; i < 300 && !c_load; i++) begin
      cycle();
      ncyc += int'(c_cyc);
    end
    check("t5_to_done", c_load, 1);
    check("t5_to_len", ncyc, TO + 1);
    check("t5_to_fault", id_fault_o, 1);
    never_ack = 0;

    // misaligned pc
    do_reset(32'h202);
    cycle();
    check("t5_mis_cyc", c_cyc, 0);
    check("t5_mis_fault", id_fault_o, 1);
    check("t5_mis_valid", id_valid_o, 1);

    // async reset during a bus cycle
    do_reset(32'h300);
    wait_cfg = 0;
    cycle(); cycle();
    stall_nxt = 1; never_ack = 1;
    cycle(); cycle();
    check("t6_pre_cyc", iport_cyc_o, 1);
    check("t6_pre_valid", id_valid_o, 1);
    #1 rst_i = 1'b0;
    #1;
    check("t6_cyc", iport_cyc_o, 0);
    check("t6_stb", iport_stb_o, 0);
    check("t6_valid", id_valid_o, 0);
    never_ack = 0;
    do_reset(32'h300);
    cycle(); cycle();
    check("t6_restart", id_pc_o, 32'h300);

    // randomized traffic
    do_reset(32'h1000);
    rnd = 1;
    for (int i = 0; i < 800; i++) begin
      stall_nxt = ($urandom_range(0, 9) < 3);
      if ((busy || hv) && $urandom_range(0, 19) == 0) begin
        flush_nxt = 1;
        redir = 32'h2000 + ($urandom_range(0, 255) << 2);
        redir_v = 1;
      end else begin
        flush_nxt = 0;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
